// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core with ROUNDS_PER_CYCLE unrolled Feistel rounds per clock.
// Optional macro DES_KEY_PARITY_CHK_EN adds key_par_err (odd parity check of each key byte).

module feistel_function (
    input  logic [47:0] k,
    input  logic [31:0] r,
    output logic [31:0] f
);
    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                                12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                                24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    logic [47:0] x;
    logic [31:0] s;

    // Table entries are 1-based DES bit numbers; DES bit 1 is the MSB of each vector.
    genvar gi;
    generate
        for (gi = 0; gi < 48; gi++) begin : g_e
            assign x[47-gi] = r[32-E_T[gi]] ^ k[47-gi];
        end
        for (gi = 0; gi < 8; gi++) begin : g_s
            logic [5:0] b;
            assign b = x[47-6*gi -: 6];
            assign s[31-4*gi -: 4] = 4'(SBOX[gi][{b[5], b[0], b[4:1]}]);
        end
        for (gi = 0; gi < 32; gi++) begin : g_p
            assign f[31-gi] = s[32-P_T[gi]];
        end
    endgenerate
endmodule

module des_decrypt_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plaintext_out
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    output logic        key_par_err
`endif
);
    localparam int RPC = ROUNDS_PER_CYCLE;
    localparam logic [4:0] RPC_W    = 5'(RPC);
    localparam logic [4:0] LAST_RND = 5'(16 - RPC);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                  10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                  14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                  23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    logic [1:0]  state_reg;
    logic [31:0] l_reg, r_reg;
    logic [27:0] c_reg, d_reg;
    logic [4:0]  rnd_reg;
    logic        out_valid_reg;
    logic [63:0] plaintext_reg;
    logic        accept;
    logic [63:0] ip_w, fp_w, pre_fp;
    logic [55:0] pc1_w;
    logic [31:0] l_s [RPC+1];
    logic [31:0] r_s [RPC+1];
    logic [27:0] c_s [RPC+1];
    logic [27:0] d_s [RPC+1];

    assign in_ready      = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    assign accept        = in_valid && in_ready;
    assign out_valid     = out_valid_reg;
    assign plaintext_out = plaintext_reg;
    assign pre_fp        = {r_s[RPC], l_s[RPC]};
    assign l_s[0] = l_reg;
    assign r_s[0] = r_reg;
    assign c_s[0] = c_reg;
    assign d_s[0] = d_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_ip_fp
            assign ip_w[63-gi] = cipher_in[64-IP_T[gi]];
            assign fp_w[63-gi] = pre_fp[64-FP_T[gi]];
        end
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_w[55-gi] = key_in[64-PC1_T[gi]];
        end
        // Unrolled rounds; the subkey schedule walks backwards by right-rotating C/D.
        for (gi = 0; gi < RPC; gi++) begin : g_rnd
            logic [4:0]  idx;
            logic        one;
            logic [27:0] c_rot, d_rot;
            logic [55:0] cd;
            logic [47:0] k;
            logic [31:0] f;
            assign idx   = rnd_reg + 5'(gi);
            assign one   = (idx == 5'd1) || (idx == 5'd8) || (idx == 5'd15);
            assign c_rot = (idx == 5'd0) ? c_s[gi] :
                           one ? {c_s[gi][0], c_s[gi][27:1]} : {c_s[gi][1:0], c_s[gi][27:2]};
            assign d_rot = (idx == 5'd0) ? d_s[gi] :
                           one ? {d_s[gi][0], d_s[gi][27:1]} : {d_s[gi][1:0], d_s[gi][27:2]};
            assign cd = {c_rot, d_rot};
            for (gj = 0; gj < 48; gj++) begin : g_pc2
                assign k[47-gj] = cd[56-PC2_T[gj]];
            end
            feistel_function u_f (.k(k), .r(r_s[gi]), .f(f));
            assign l_s[gi+1] = r_s[gi];
            assign r_s[gi+1] = l_s[gi] ^ f;
            assign c_s[gi+1] = c_rot;
            assign d_s[gi+1] = d_rot;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            l_reg         <= '0;
            r_reg         <= '0;
            c_reg         <= '0;
            d_reg         <= '0;
            rnd_reg       <= '0;
            out_valid_reg <= 1'b0;
            plaintext_reg <= '0;
        end else begin
            if (accept) begin
                l_reg     <= ip_w[63:32];
                r_reg     <= ip_w[31:0];
                c_reg     <= pc1_w[55:28];
                d_reg     <= pc1_w[27:0];
                rnd_reg   <= '0;
                state_reg <= ROUND;
            end
            case (state_reg)
                IDLE: ;
                ROUND: begin
                    l_reg   <= l_s[RPC];
                    r_reg   <= r_s[RPC];
                    c_reg   <= c_s[RPC];
                    d_reg   <= d_s[RPC];
                    rnd_reg <= rnd_reg + RPC_W;
                    if (rnd_reg == LAST_RND) begin
                        plaintext_reg <= fp_w;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (!accept) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef DES_KEY_PARITY_CHK_EN
    logic [7:0] byte_bad;
    logic       par_pend_reg, par_err_reg;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_par
            assign byte_bad[gi] = ~^key_in[8*gi +: 8];
        end
    endgenerate
    // Flag follows its block: captured at accept, exposed with out_valid, dropped on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_pend_reg <= 1'b0;
            par_err_reg  <= 1'b0;
        end else begin
            if (accept) par_pend_reg <= |byte_bad;
            if ((state_reg == ROUND) && (rnd_reg == LAST_RND)) par_err_reg <= par_pend_reg;
            else if ((state_reg == DONE) && out_ready) par_err_reg <= 1'b0;
        end
    end
    assign key_par_err = par_err_reg;
`else
    logic [7:0] unused_par;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unused
            assign unused_par[gi] = key_in[8*gi];
        end
    endgenerate
`endif
endmodule
